// File: rtl/rob_pkg.sv
// Shared types and default widths for the multi-retire reorder buffer.
package rob_pkg;
  localparam int DEF_DEPTH        = 32;
  localparam int DEF_FU_COUNT     = 4;
  localparam int DEF_MAX_OPERANDS = 3;
  localparam int DEF_PRN_BITS     = 6;
  localparam int DEF_ARN_BITS     = 6;
  localparam int DEF_RETIRE_WIDTH = 2;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} rob_state_e;

  // Entry layout at the default configuration; the top re-declares it with its own widths.
  typedef struct packed {
    logic                                             valid;
    logic                                             done;
    logic [63:0]                                      pc;
    logic [DEF_MAX_OPERANDS-1:0]                      map_valid;
    logic [DEF_MAX_OPERANDS-1:0][DEF_ARN_BITS-1:0]    map_arn;
    logic [DEF_MAX_OPERANDS-1:0][DEF_PRN_BITS-1:0]    map_prn;
  } rob_entry_t;
endpackage

// File: rtl/rob_retire_select.sv
// Contiguous valid&done scan starting at head; yields per-slot retire mask and count.
module rob_retire_select #(
  parameter int DEPTH        = 32,
  parameter int ID_BITS      = $clog2(DEPTH),
  parameter int RETIRE_WIDTH = 2,
  parameter int CNT_W        = $clog2(RETIRE_WIDTH+1)
)(
  input  logic [DEPTH-1:0]        valid,
  input  logic [DEPTH-1:0]        done,
  input  logic [ID_BITS-1:0]      head,
  input  logic                    enable,
  output logic [RETIRE_WIDTH-1:0] mask,
  output logic [CNT_W-1:0]        count
);
  logic               run;
  logic [ID_BITS-1:0] idx;

  always_comb begin
    run   = enable;
    idx   = head;
    mask  = '0;
    count = '0;
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      idx     = head + ID_BITS'(k);
      run     = run & valid[idx] & done[idx];
      mask[k] = run;
      if (run) count = count + CNT_W'(1);
    end
  end
endmodule

// File: rtl/rob_multi.sv
// Multi-retire reorder buffer with one-entry-per-cycle flush walk-back.
// Optional perf counters enabled by defining ROB_MULTI_PERF_EN.
module rob_multi import rob_pkg::*; #(
  parameter int DEPTH        = DEF_DEPTH,
  parameter int ID_BITS      = $clog2(DEPTH),
  parameter int FU_COUNT     = DEF_FU_COUNT,
  parameter int MAX_OPERANDS = DEF_MAX_OPERANDS,
  parameter int PRN_BITS     = DEF_PRN_BITS,
  parameter int ARN_BITS     = DEF_ARN_BITS,
  parameter int RETIRE_WIDTH = DEF_RETIRE_WIDTH
)(
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               inst_valid,
  output logic                                               inst_ready,
  input  logic [63:0]                                        pc,
  input  logic [MAX_OPERANDS-1:0]                            mapping_inputs_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]              mapping_inputs_prn,
  input  logic [MAX_OPERANDS-1:0][ARN_BITS-1:0]              mapping_inputs_arn,
  output logic [ID_BITS-1:0]                                 new_inst_id,
  input  logic [FU_COUNT-1:0]                                fu_out_inst_valid,
  input  logic [FU_COUNT-1:0][ID_BITS-1:0]                   fu_out_inst_ids,
  output logic [RETIRE_WIDTH-1:0]                            retire_inst_valid,
  output logic [RETIRE_WIDTH-1:0][ID_BITS-1:0]               retire_inst_id,
  output logic [RETIRE_WIDTH*MAX_OPERANDS-1:0]               freed_prns_valid,
  output logic [RETIRE_WIDTH*MAX_OPERANDS-1:0][PRN_BITS-1:0] freed_prns,
  input  logic                                               start_flush,
  input  logic [ID_BITS-1:0]                                 start_flush_to,
  output logic [MAX_OPERANDS-1:0]                            reset_valid,
  output logic [MAX_OPERANDS-1:0][ARN_BITS-1:0]              arn_reset,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]              prn_reset,
  output logic                                               stall_rename,
  output logic [ID_BITS:0]                                   occupancy
`ifdef ROB_MULTI_PERF_EN
  ,
  output logic [63:0]                                        perf_retired,
  output logic [31:0]                                        perf_flush_cycles
`endif
);
  localparam int CNT_W = $clog2(RETIRE_WIDTH+1);

  typedef struct packed {
    logic                                     valid;
    logic                                     done;
    logic [63:0]                              pc;
    logic [MAX_OPERANDS-1:0]                  map_valid;
    logic [MAX_OPERANDS-1:0][ARN_BITS-1:0]    map_arn;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    map_prn;
  } entry_t;

  entry_t             ent [DEPTH];
  logic [ID_BITS:0]   head, tail;
  logic [ID_BITS-1:0] head_idx, tail_idx, last_idx, target;
  rob_state_e         state, state_nxt;
  logic               empty, full, flush_req, dispatch, walk;
  logic [DEPTH-1:0]   vld_vec, done_vec;
  logic [CNT_W-1:0]   retire_cnt;

  assign head_idx     = head[ID_BITS-1:0];
  assign tail_idx     = tail[ID_BITS-1:0];
  assign last_idx     = tail_idx - 1'b1;
  assign empty        = (head == tail);
  assign full         = (head_idx == tail_idx) && (head[ID_BITS] != tail[ID_BITS]);
  assign flush_req    = (state == RUN) && start_flush && !empty;
  // The flush request cycle blocks dispatch as well as retire.
  assign inst_ready   = !full && (state == RUN) && !flush_req;
  assign dispatch     = inst_valid && inst_ready;
  assign new_inst_id  = tail_idx;
  assign occupancy    = tail - head;
  assign walk         = (state == FLUSH) && (last_idx != target);
  assign stall_rename = (state == FLUSH) || flush_req;

  genvar i, k, o;
  for (i = 0; i < DEPTH; i++) begin : g_vec
    assign vld_vec[i]  = ent[i].valid;
    assign done_vec[i] = ent[i].done;
  end

  rob_retire_select #(.DEPTH(DEPTH), .ID_BITS(ID_BITS), .RETIRE_WIDTH(RETIRE_WIDTH)) u_sel (
    .valid (vld_vec),
    .done  (done_vec),
    .head  (head_idx),
    .enable((state == RUN) && !flush_req),
    .mask  (retire_inst_valid),
    .count (retire_cnt)
  );

  for (k = 0; k < RETIRE_WIDTH; k++) begin : g_slot
    logic [ID_BITS-1:0] idx;
    assign idx               = head_idx + ID_BITS'(k);
    assign retire_inst_id[k] = retire_inst_valid[k] ? idx : '0;
    for (o = 0; o < MAX_OPERANDS; o++) begin : g_op
      assign freed_prns_valid[k*MAX_OPERANDS+o] = retire_inst_valid[k] & ent[idx].map_valid[o];
      assign freed_prns[k*MAX_OPERANDS+o]       = retire_inst_valid[k] ? ent[idx].map_prn[o] : '0;
    end
  end

  assign reset_valid = walk ? ent[last_idx].map_valid : '0;
  assign arn_reset   = walk ? ent[last_idx].map_arn   : '0;
  assign prn_reset   = walk ? ent[last_idx].map_prn   : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (flush_req) state_nxt = FLUSH;
      FLUSH:   if (!walk)     state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head   <= '0;
      tail   <= '0;
      state  <= RUN;
      target <= '0;
      for (int e = 0; e < DEPTH; e++) ent[e] <= '0;
    end else begin
      state <= state_nxt;
      if (flush_req) target <= start_flush_to;
      for (int f = 0; f < FU_COUNT; f++)
        if (fu_out_inst_valid[f] && ent[fu_out_inst_ids[f]].valid) ent[fu_out_inst_ids[f]].done <= 1'b1;
      // Later writes win: retire and walk-back clears override a same-cycle done set.
      for (int r = 0; r < RETIRE_WIDTH; r++)
        if (retire_inst_valid[r]) ent[head_idx + ID_BITS'(r)] <= '0;
      head <= head + (ID_BITS+1)'(retire_cnt);
      if (dispatch) begin
        ent[tail_idx] <= '{valid: 1'b1, done: 1'b0, pc: pc, map_valid: mapping_inputs_valid,
                           map_arn: mapping_inputs_arn, map_prn: mapping_inputs_prn};
        tail <= tail + 1'b1;
      end
      if (walk) begin
        ent[last_idx].valid <= 1'b0;
        ent[last_idx].done  <= 1'b0;
        tail <= tail - 1'b1;
      end
    end
  end

`ifdef ROB_MULTI_PERF_EN
  logic [64:0] ret_sum;
  assign ret_sum = {1'b0, perf_retired} + 65'(retire_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_retired      <= '0;
      perf_flush_cycles <= '0;
    end else begin
      perf_retired <= ret_sum[64] ? '1 : ret_sum[63:0];
      if (state == FLUSH && perf_flush_cycles != '1) perf_flush_cycles <= perf_flush_cycles + 1'b1;
    end
  end
`endif
endmodule
